// File: rtl/pad_game_pkg.sv
// Shared types and constants for the pad game: round states, LFSR shape, score width
// and the processor-side MMIO map.
package pad_game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StLit,
        StMiss,
        StOver
    } state_e;

    localparam int unsigned LFSR_W = 16;
    // Galois right-shift mask for taps 16,14,13,11
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned SCORE_W = 32;

    localparam logic [2:0] MMIO_SENSOR     = 3'd0;
    localparam logic [2:0] MMIO_LIGHTS     = 3'd1;
    localparam logic [2:0] MMIO_CONTROLLER = 3'd2;
    localparam logic [2:0] MMIO_SCREEN     = 3'd3;
    localparam logic [2:0] MMIO_SCORE      = 3'd4;
    localparam logic [2:0] MMIO_MISTAKE    = 3'd5;

    function automatic logic [LFSR_W-1:0] lfsr_step(logic [LFSR_W-1:0] cur);
        return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
    endfunction

    // Folds a 2-bit random value into 0..num_pads-1
    function automatic logic [1:0] pad_select(logic [1:0] raw, int unsigned num_pads);
        if (32'(raw) >= num_pads) return raw - 2'(num_pads);
        return raw;
    endfunction

endpackage

// File: rtl/pad_edge_sync.sv
// Per-pad two-flop synchronizer followed by a rising-edge detector.
module pad_edge_sync #(
    parameter int unsigned NUM_PADS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_PADS-1:0] sensor_in,
    output logic [NUM_PADS-1:0] rise
);

    logic [NUM_PADS-1:0] meta_q;
    logic [NUM_PADS-1:0] sync_q;
    logic [NUM_PADS-1:0] prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= sensor_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/pad_round_sequencer.sv
// Pad game round controller: lights a random pad, judges hit / wrong pad / timeout and
// keeps score and miss status. Define SPEEDUP_EN to shorten the timeout every 8 hits.
module pad_round_sequencer
    import pad_game_pkg::*;
#(
    parameter int unsigned NUM_PADS       = 3,
    parameter int unsigned GAP_CYCLES     = 5000000,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned MAX_MISSES     = 3,
`ifdef SPEEDUP_EN
    parameter int unsigned TIMEOUT_STEP   = 2500000,
    parameter int unsigned MIN_TIMEOUT    = 10000000,
`endif
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_PADS-1:0] sensor_in,
    output logic [NUM_PADS-1:0] light_out,
    output logic [SCORE_W-1:0]  score,
    output logic                mistake,
    output logic [1:0]          misses_left,
    output logic                game_over,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [31:0]         gap_q, gap_d;
    logic [31:0]         tmo_q, tmo_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [NUM_PADS-1:0] light_q, light_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                mistake_q, mistake_d;
    logic [1:0]          misses_q, misses_d;
    logic                over_q, over_d;
    logic                busy_q, busy_d;

    logic [NUM_PADS-1:0] rise;
    logic                hit_any;
    logic                wrong_any;
    logic                game_start;
    logic                good_hit;
    logic [31:0]         active_tmo;

    pad_edge_sync #(
        .NUM_PADS (NUM_PADS)
    ) u_edge_sync (
        .clock     (clock),
        .reset     (reset),
        .sensor_in (sensor_in),
        .rise      (rise)
    );

    assign hit_any    = |(rise & light_q);
    assign wrong_any  = |(rise & ~light_q);
    assign game_start = !abort && start && (state_q == StIdle || state_q == StOver);
    assign good_hit   = !abort && (state_q == StLit) && hit_any && !wrong_any;

`ifdef SPEEDUP_EN
    logic [2:0]  hit_cnt_q;
    logic [31:0] active_tmo_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt_q    <= 3'd0;
            active_tmo_q <= TIMEOUT_CYCLES;
        end else if (game_start) begin
            hit_cnt_q    <= 3'd0;
            active_tmo_q <= TIMEOUT_CYCLES;
        end else if (good_hit) begin
            hit_cnt_q <= hit_cnt_q + 3'd1;
            if (hit_cnt_q == 3'd7) begin
                active_tmo_q <= (active_tmo_q >= MIN_TIMEOUT + TIMEOUT_STEP) ?
                                active_tmo_q - TIMEOUT_STEP : MIN_TIMEOUT;
            end
        end
    end

    assign active_tmo = active_tmo_q;
`else
    assign active_tmo = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        light_d   = '0;
        score_d   = score_q;
        mistake_d = mistake_q;
        misses_d  = misses_q;

        if (abort) begin
            state_d   = StIdle;
            mistake_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StOver: begin
                    if (start) begin
                        state_d   = StGap;
                        gap_d     = GAP_CYCLES - 1;
                        score_d   = '0;
                        mistake_d = 1'b0;
                        misses_d  = 2'(MAX_MISSES);
                    end
                end
                StGap: begin
                    if (gap_q == 32'd0) begin
                        state_d   = StLit;
                        tmo_d     = active_tmo - 32'd1;
                        mistake_d = 1'b0;
                        light_d   = NUM_PADS'(1) << pad_select(lfsr_q[1:0], NUM_PADS);
                    end else begin
                        gap_d = gap_q - 32'd1;
                    end
                end
                StLit: begin
                    // A wrong pad beats a simultaneous correct one; any edge beats expiry
                    if (wrong_any || (!hit_any && tmo_q == 32'd0)) begin
                        state_d   = StMiss;
                        mistake_d = 1'b1;
                        misses_d  = misses_q - 2'd1;
                    end else if (hit_any) begin
                        state_d = StGap;
                        gap_d   = GAP_CYCLES - 1;
                        score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                    end else begin
                        tmo_d   = tmo_q - 32'd1;
                        light_d = light_q;
                    end
                end
                StMiss: begin
                    state_d = (misses_q == 2'd0) ? StOver : StGap;
                    gap_d   = GAP_CYCLES - 1;
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StGap) || (state_d == StLit) || (state_d == StMiss);
        over_d = (state_d == StOver);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            gap_q     <= 32'd0;
            tmo_q     <= 32'd0;
            lfsr_q    <= LFSR_SEED;
            light_q   <= '0;
            score_q   <= '0;
            mistake_q <= 1'b0;
            misses_q  <= 2'(MAX_MISSES);
            over_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            lfsr_q    <= lfsr_step(lfsr_q);
            light_q   <= light_d;
            score_q   <= score_d;
            mistake_q <= mistake_d;
            misses_q  <= misses_d;
            over_q    <= over_d;
            busy_q    <= busy_d;
        end
    end

    assign light_out   = light_q;
    assign score       = score_q;
    assign mistake     = mistake_q;
    assign misses_left = misses_q;
    assign game_over   = over_q;
    assign busy        = busy_q;

endmodule
